// File: rtl/plru_set_array.sv
// rtl/plru_set_array.sv - tree-PLRU state array shared by a fill (victim) port and a touch (hit) port,
// with a sweep FSM that returns every set to the all-zero encoding.

module plru_updater #(
  parameter int NUM_ENTRIES     = 8,
  parameter int LOG_NUM_ENTRIES = $clog2(NUM_ENTRIES)
) (
  input  logic [NUM_ENTRIES-2:0]     plru_in,
  input  logic                       update_valid,
  input  logic [LOG_NUM_ENTRIES-1:0] update_way,
  output logic [NUM_ENTRIES-2:0]     plru_out
);
  // Level l holds 2^l nodes starting at 2^l-1, indexed by the way's low l bits;
  // each node decides way bit l. Marking MRU points every node on the path away.
  always_comb begin
    plru_out = plru_in;
    if (update_valid) begin
      for (int l = 0; l < LOG_NUM_ENTRIES; l++) begin
        plru_out[LOG_NUM_ENTRIES'((1 << l) - 1) + (update_way & LOG_NUM_ENTRIES'((1 << l) - 1))] = ~update_way[l];
      end
    end
  end
endmodule

module plru_set_array #(
  parameter int NUM_SETS        = 16,
  parameter int LOG_NUM_SETS    = $clog2(NUM_SETS),
  parameter int NUM_ENTRIES     = 8,
  parameter int LOG_NUM_ENTRIES = $clog2(NUM_ENTRIES)
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       fill_req_valid,
  input  logic [LOG_NUM_SETS-1:0]    fill_req_set,
  output logic                       fill_req_ready,
  output logic                       fill_resp_valid,
  output logic [LOG_NUM_ENTRIES-1:0] fill_resp_way,
  input  logic                       touch_valid,
  input  logic [LOG_NUM_SETS-1:0]    touch_set,
  input  logic [LOG_NUM_ENTRIES-1:0] touch_way,
  input  logic                       clear_req,
  output logic                       clear_busy
);
  localparam int W = NUM_ENTRIES - 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                      state;
  logic [LOG_NUM_SETS-1:0]     clr_cnt;
  logic [W-1:0]                plru [NUM_SETS];

  logic                        fill_fire;
  logic                        touch_fire;
  logic                        same_set;
  logic [W-1:0]                touch_in;
  logic [W-1:0]                touch_out;
  logic [W-1:0]                new_in;
  logic [W-1:0]                new_out;
  logic [LOG_NUM_ENTRIES-1:0]  victim;

  function automatic logic [LOG_NUM_ENTRIES-1:0] find_victim(input logic [W-1:0] v);
    logic [LOG_NUM_ENTRIES-1:0] way;
    way = '0;
    for (int l = 0; l < LOG_NUM_ENTRIES; l++) begin
      way[l] = v[LOG_NUM_ENTRIES'((1 << l) - 1) + (way & LOG_NUM_ENTRIES'((1 << l) - 1))];
    end
    return way;
  endfunction

  assign fill_fire  = fill_req_valid && fill_req_ready;
  assign touch_fire = touch_valid && (state == IDLE);
  assign same_set   = fill_fire && touch_fire && (fill_req_set == touch_set);

  // A same-set touch feeds the fill stage so the victim comes from the post-touch vector.
  assign touch_in = plru[touch_set];
  assign new_in   = same_set ? touch_out : plru[fill_req_set];
  assign victim   = find_victim(new_in);

  plru_updater #(.NUM_ENTRIES(NUM_ENTRIES), .LOG_NUM_ENTRIES(LOG_NUM_ENTRIES)) u_touch (
    .plru_in      (touch_in),
    .update_valid (touch_fire),
    .update_way   (touch_way),
    .plru_out     (touch_out)
  );

  plru_updater #(.NUM_ENTRIES(NUM_ENTRIES), .LOG_NUM_ENTRIES(LOG_NUM_ENTRIES)) u_new (
    .plru_in      (new_in),
    .update_valid (fill_fire),
    .update_way   (victim),
    .plru_out     (new_out)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state           <= IDLE;
      clr_cnt         <= '0;
      fill_req_ready  <= 1'b1;
      fill_resp_valid <= 1'b0;
      fill_resp_way   <= '0;
      clear_busy      <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) plru[s] <= '0;
    end else begin
      fill_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (touch_fire && !same_set) plru[touch_set] <= touch_out;
          if (fill_fire) begin
            plru[fill_req_set] <= new_out;
            fill_resp_valid    <= 1'b1;
            fill_resp_way      <= victim;
          end
          if (clear_req) begin
            state          <= CLEAR;
            clear_busy     <= 1'b1;
            fill_req_ready <= 1'b0;
          end
        end
        CLEAR: begin
          plru[clr_cnt] <= '0;
          clr_cnt       <= clr_cnt + 1'b1;
          if (clr_cnt == LOG_NUM_SETS'(NUM_SETS - 1)) begin
            state          <= IDLE;
            clear_busy     <= 1'b0;
            fill_req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_plru_set_array.sv
// tb/tb_plru_set_array.sv - scoreboard bench for plru_set_array with a reference tree-PLRU model.

module tb_plru_set_array;
  localparam int NS = 16;
  localparam int NE = 8;

  logic       CLK;
  logic       nRST;
  logic       fill_req_valid;
  logic [3:0] fill_req_set;
  logic       fill_req_ready;
  logic       fill_resp_valid;
  logic [2:0] fill_resp_way;
  logic       touch_valid;
  logic [3:0] touch_set;
  logic [2:0] touch_way;
  logic       clear_req;
  logic       clear_busy;

  int         checks   = 0;
  int         failures = 0;
  int         sb[$];
  logic [6:0] m [NS];

  plru_set_array #(.NUM_SETS(NS), .NUM_ENTRIES(NE)) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .fill_req_valid  (fill_req_valid),
    .fill_req_set    (fill_req_set),
    .fill_req_ready  (fill_req_ready),
    .fill_resp_valid (fill_resp_valid),
    .fill_resp_way   (fill_resp_way),
    .touch_valid     (touch_valid),
    .touch_set       (touch_set),
    .touch_way       (touch_way),
    .clear_req       (clear_req),
    .clear_busy      (clear_busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: node for level l is (2^l - 1) + (way mod 2^l); node bit gives way bit l.
  function automatic logic [6:0] m_mark(input logic [6:0] v, input int way);
    logic [6:0] r;
    r = v;
    for (int l = 0; l < 3; l++) r[3'((1 << l) - 1 + way % (1 << l))] = (((way >> l) & 1) == 0);
    return r;
  endfunction

  function automatic int m_victim(input logic [6:0] v);
    int w;
    w = 0;
    for (int l = 0; l < 3; l++) if (v[3'((1 << l) - 1 + w)]) w += (1 << l);
    return w;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < NS; s++) m[s] = '0;
  endtask

  // One request cycle; exp >= 0 overrides the model's victim with a hand-derived value.
  task automatic cyc(input bit fv, input int fs, input bit tv, input int ts, input int tw, input int exp);
    int n;
    int w;
    n = 0;
    fill_req_valid = fv;
    fill_req_set   = 4'(fs);
    touch_valid    = tv;
    touch_set      = 4'(ts);
    touch_way      = 3'(tw);
    @(negedge CLK);
    while (fv && fill_req_ready !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n == 50) check("fill_ready_timeout", 32'd0, 32'd1);
    if (tv) m[ts] = m_mark(m[ts], tw);
    if (fv) begin
      w = m_victim(m[fs]);
      m[fs] = m_mark(m[fs], w);
      sb.push_back(exp >= 0 ? exp : w);
    end
    @(posedge CLK);
    #1;
    fill_req_valid = 1'b0;
    touch_valid    = 1'b0;
    clear_req      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (fill_resp_valid === 1'b1) begin
        if (sb.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
        else check("resp_way", 32'(fill_resp_way), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    int ways[8] = '{7, 5, 3, 1, 6, 4, 2, 0};
    nRST           = 1'b0;
    fill_req_valid = 1'b0;
    fill_req_set   = '0;
    touch_valid    = 1'b0;
    touch_set      = '0;
    touch_way      = '0;
    clear_req      = 1'b0;
    model_clear();
    repeat (2) @(negedge CLK);
    check("rst_ready", 32'(fill_req_ready), 32'd1);
    check("rst_resp_valid", 32'(fill_resp_valid), 32'd0);
    check("rst_resp_way", 32'(fill_resp_way), 32'd0);
    check("rst_busy", 32'(clear_busy), 32'd0);
    nRST = 1'b1;
    idle(1);

    // back-to-back fills on set 3, then probe the written state 0111_10_1
    cyc(1, 3, 0, 0, 0, 0);
    cyc(1, 3, 0, 0, 0, 1);
    cyc(1, 3, 0, 0, 0, 2);
    cyc(1, 3, 0, 0, 0, 3);
    idle(1);

    // touch sweep on set 2 leaves all ones; fill picks 7 then state 0111_01_0 picks 6
    foreach (ways[i]) cyc(0, 0, 1, 2, ways[i], -1);
    cyc(1, 2, 0, 0, 0, 7);
    cyc(1, 2, 0, 0, 0, 6);

    // same-set touch + fill on set 4, then state 0011_11_0 picks 2
    cyc(1, 4, 1, 4, 0, 1);
    cyc(1, 4, 0, 0, 0, 2);

    // fill set 1 alongside touch set 9 way 5
    cyc(1, 1, 1, 9, 5, 0);
    cyc(1, 1, 0, 0, 0, 1);
    cyc(1, 9, 0, 0, 0, 0);
    cyc(1, 9, 0, 0, 0, 3);
    idle(1);

    // clear sweep; a fill presented with clear_req still completes
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 15, 0, -1);
    clear_req = 1'b1;
    cyc(1, 5, 0, 0, 0, 0);
    model_clear();
    for (int k = 0; k < 16; k++) begin
      fill_req_valid = 1'b1;
      fill_req_set   = 4'd0;
      touch_valid    = (k == 10);
      touch_set      = 4'd0;
      touch_way      = 3'd0;
      clear_req      = (k == 3);
      @(negedge CLK);
      if (k == 0 || k == 15) begin
        check("clr_busy", 32'(clear_busy), 32'd1);
        check("clr_ready", 32'(fill_req_ready), 32'd0);
      end
      @(posedge CLK);
      #1;
    end
    fill_req_valid = 1'b0;
    touch_valid    = 1'b0;
    clear_req      = 1'b0;
    @(negedge CLK);
    check("clr_done_busy", 32'(clear_busy), 32'd0);
    check("clr_done_ready", 32'(fill_req_ready), 32'd1);
    @(posedge CLK);
    #1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 15, 0, 0, 0, 0);
    idle(1);

    // reset in the middle of a sweep
    cyc(0, 0, 1, 8, 0, -1);
    clear_req = 1'b1;
    cyc(0, 0, 0, 0, 0, -1);
    repeat (5) @(posedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    check("rst_mid_busy", 32'(clear_busy), 32'd0);
    check("rst_mid_ready", 32'(fill_req_ready), 32'd1);
    @(negedge CLK);
    nRST = 1'b1;
    model_clear();
    @(posedge CLK);
    #1;
    cyc(1, 8, 0, 0, 0, 0);

    // random mixed traffic against the model
    repeat (60) begin
      cyc($urandom_range(0, 1), $urandom_range(0, NS - 1), $urandom_range(0, 1),
          $urandom_range(0, NS - 1), $urandom_range(0, NE - 1), -1);
    end
    idle(3);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
